// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, drives the ICACHE read handshake and buffers
// responses in a DEPTH-entry queue. Define IFETCH_PREDECODE_EN to follow j/jal in fetch.
module ifetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ICACHE_ren,
  output logic                   ICACHE_wen,
  output logic [ADDR_W-1:0]      ICACHE_addr,
  output logic [31:0]            ICACHE_wdata,
  input  logic                   ICACHE_stall,
  input  logic [31:0]            ICACHE_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   id_ready,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [ADDR_W-1:0]      inst_pc4,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StFetch, StDrop} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q, hold_addr_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [31:0]         mem_inst_q [DEPTH];
  logic [ADDR_W-1:0]   mem_pc4_q  [DEPTH];

  logic              fetch_st, accept, push, pop;
  logic [ADDR_W-1:0] pc4, fetch_next_pc;

  assign fetch_st = (state_q == StFetch);
  // ren is forced low while reset is asserted; FETCH throttles on registered occupancy.
  assign ICACHE_ren   = rst & (fetch_st ? (count_q < CntW'(DEPTH)) : 1'b1);
  assign ICACHE_addr  = fetch_st ? pc_q : hold_addr_q;
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;

  assign accept = ICACHE_ren & ~ICACHE_stall;
  assign push   = fetch_st & accept & ~redirect_valid;
  assign pop    = (count_q != '0) & id_ready & ~redirect_valid;
  assign pc4    = pc_q + ADDR_W'(4);

`ifdef IFETCH_PREDECODE_EN
  logic              is_jump;
  logic [ADDR_W-1:0] jump_tgt;
  // j/jal opcodes 6'h02/6'h03; target keeps the upper PC+4 bits above bit 27.
  assign is_jump  = (ICACHE_rdata[31:27] == 5'b00001);
  assign jump_tgt = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({ICACHE_rdata[25:0], 2'b00});
  assign fetch_next_pc = is_jump ? jump_tgt : pc4;
`else
  assign fetch_next_pc = pc4;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      hold_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // A stalled request cannot be abandoned: keep presenting it and drop its data.
      if (fetch_st && ICACHE_ren && ICACHE_stall) begin
        hold_addr_q <= pc_q;
        state_q     <= StDrop;
      end
    end else begin
      if (push) begin
        pc_q     <= fetch_next_pc;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (!fetch_st && accept) state_q <= StFetch;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= ICACHE_rdata;
      mem_pc4_q[wr_ptr_q]  <= pc4;
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? mem_inst_q[rd_ptr_q] : '0;
  assign inst_pc4   = inst_valid ? mem_pc4_q[rd_ptr_q] : '0;
  assign q_count    = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch stream, full queue, stall, redirect/drop, predecode.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren, wen;
  logic [31:0] addr, wdata;
  logic        stall = 1'b0;
  logic [31:0] rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        inst_valid;
  logic [31:0] inst, inst_pc4;
  logic [2:0]  q_count;
  logic        jump_ovr = 1'b0;
  logic [31:0] exp_jump_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // The cache returns the address as data, except for one injected j instruction.
  always_comb begin
    rdata = addr;
    if (jump_ovr && addr == 32'h8) rdata = 32'h0800_0100;
  end

  ifetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .ICACHE_ren     (ren),
    .ICACHE_wen     (wen),
    .ICACHE_addr    (addr),
    .ICACHE_wdata   (wdata),
    .ICACHE_stall   (stall),
    .ICACHE_rdata   (rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc4       (inst_pc4),
    .q_count        (q_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef IFETCH_PREDECODE_EN
    exp_jump_addr = 32'h400;
`else
    exp_jump_addr = 32'hC;
`endif
    #2;
    check_eq("rst_ren", {31'b0, ren}, 32'h0);
    check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rst_count", {29'b0, q_count}, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_pc4", inst_pc4, 32'h0);
    check_eq("rst_wen", {31'b0, wen}, 32'h0);
    check_eq("rst_wdata", wdata, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("rel_ren", {31'b0, ren}, 32'h1);
    check_eq("rel_addr", addr, 32'h0);

    // Streaming: one instruction per cycle with the queue holding a single entry.
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("stream_valid", {31'b0, inst_valid}, 32'h1);
      check_eq("stream_pc4", inst_pc4, 32'(4 * i));
      check_eq("stream_inst", inst, 32'(4 * (i - 1)));
      check_eq("stream_cnt", {29'b0, q_count}, 32'h1);
    end

    // Fill: from one entry, three pushes reach DEPTH and ren drops.
    id_ready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_eq("fill_cnt", {29'b0, q_count}, 32'(i));
    end
    check_eq("full_ren", {31'b0, ren}, 32'h0);
    tick();
    check_eq("full_hold_cnt", {29'b0, q_count}, 32'h4);
    check_eq("full_addr", addr, 32'h18);
    check_eq("full_head", inst_pc4, 32'hC);

    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check_eq("pop1_cnt", {29'b0, q_count}, 32'h3);
    check_eq("pop1_ren", {31'b0, ren}, 32'h1);
    check_eq("pop1_head", inst_pc4, 32'h10);

    // Redirect coinciding with an accept and a pop.
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check_eq("rdr_cnt", {29'b0, q_count}, 32'h0);
    check_eq("rdr_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rdr_addr", addr, 32'h10);

    // Stall for three cycles: request must be held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_addr", addr, 32'h10);
      check_eq("stall_ren", {31'b0, ren}, 32'h1);
      check_eq("stall_cnt", {29'b0, q_count}, 32'h0);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_pc4", inst_pc4, 32'h14);
    check_eq("unstall_inst", inst, 32'h10);
    tick();
    check_eq("post_pc4", inst_pc4, 32'h18);
    tick();
    tick();
    check_eq("pre_drop_addr", addr, 32'h20);

    // Redirect while 0x20 is stalled: enter DROP.
    stall = 1'b1;
    tick();
    check_eq("stl20_addr", addr, 32'h20);
    check_eq("stl20_cnt", {29'b0, q_count}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check_eq("drop_cnt", {29'b0, q_count}, 32'h0);
    check_eq("drop_addr", addr, 32'h20);
    check_eq("drop_ren", {31'b0, ren}, 32'h1);
    tick();
    check_eq("drop_hold_addr", addr, 32'h20);
    stall = 1'b0;
    tick();
    check_eq("dropdone_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("dropdone_addr", addr, 32'h40);
    tick();
    check_eq("after_drop_pc4", inst_pc4, 32'h44);
    check_eq("after_drop_inst", inst, 32'h40);

    // Jump predecode at PC 0x8.
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    check_eq("j_setup_addr", addr, 32'h8);
    id_ready = 1'b0;
    jump_ovr = 1'b1;
    tick();
    jump_ovr = 1'b0;
    check_eq("j_inst", inst, 32'h0800_0100);
    check_eq("j_pc4", inst_pc4, 32'hC);
    check_eq("j_cnt", {29'b0, q_count}, 32'h1);
    check_eq("j_next_addr", addr, exp_jump_addr);

    // Reset mid-operation clears state immediately.
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_cnt", {29'b0, q_count}, 32'h0);
    check_eq("mid_rst_ren", {31'b0, ren}, 32'h0);
    check_eq("mid_rst_pc4", inst_pc4, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rel_addr", addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
